// File: rtl/uart_rx_fifo_if.sv
// Write-side handshake between the UART receiver and its downstream byte FIFO.
// The receiver is the master (drives the write strobe/data, observes full).
interface uart_rx_fifo_if;
    logic       wfifo_full;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_wr_data;

    modport master (
        input  wfifo_full,
        output wfifo_wr_en,
        output wfifo_wr_data
    );

    modport slave (
        output wfifo_full,
        input  wfifo_wr_en,
        input  wfifo_wr_data
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: mid-bit sampling of a synchronized line, good bytes pushed
// into a write FIFO, framing errors and FIFO overflows reported as 1-cycle pulses.
module uart_rx_fifo #(
    parameter int BAND_TIME = 5207,
    parameter int HALF_TIME = BAND_TIME / 2
) (
    input  logic           s_clk,
    input  logic           s_rst_n,
    input  logic           data_rx,
    uart_rx_fifo_if.master wfifo,
    output logic           frame_err,
    output logic           overflow,
    output logic           rx_busy
);

    localparam logic [12:0] BAND_MAX = 13'(BAND_TIME);
    localparam logic [12:0] HALF_MID = 13'(HALF_TIME);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_d;
    logic [12:0] r_band_cnt;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_wr_en;
    logic [7:0]  r_wr_data;
    logic        r_frame_err;
    logic        r_overflow;

    logic w_fall;
    logic w_mid;
    logic w_bit_end;

    assign w_fall    = r_rx_d & ~r_rx_s2;
    assign w_mid     = (r_band_cnt == HALF_MID);
    assign w_bit_end = (r_band_cnt == BAND_MAX);

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state     <= IDLE;
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_d      <= 1'b1;
            r_band_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_rx_s1     <= data_rx;
            r_rx_s2     <= r_rx_s1;
            r_rx_d      <= r_rx_s2;
            r_wr_en     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;

            if (r_state == IDLE || w_bit_end)
                r_band_cnt <= '0;
            else
                r_band_cnt <= r_band_cnt + 13'd1;

            if (r_state != IDLE && w_bit_end)
                r_bit_cnt <= r_bit_cnt + 4'd1;

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state   <= START;
                        r_bit_cnt <= '0;
                    end
                end
                START: begin
                    // A start bit that is already high again at mid-bit was a glitch.
                    if (w_mid && r_rx_s2) begin
                        r_state    <= IDLE;
                        r_band_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end else if (w_bit_end) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_mid)
                        r_shift <= {r_rx_s2, r_shift[7:1]};
                    if (w_bit_end && r_bit_cnt == 4'd8)
                        r_state <= STOP;
                end
                STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is not missed.
                    if (w_mid) begin
                        r_state    <= IDLE;
                        r_band_cnt <= '0;
                        r_bit_cnt  <= '0;
                        if (!r_rx_s2) begin
                            r_frame_err <= 1'b1;
                        end else if (wfifo.wfifo_full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= r_shift;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wfifo.wfifo_wr_en   = r_wr_en;
    assign wfifo.wfifo_wr_data = r_wr_data;
    assign frame_err           = r_frame_err;
    assign overflow            = r_overflow;
    assign rx_busy             = (r_state != IDLE);

endmodule
